// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_pkg                                                       |
// | Default 640x480@60 raster constants and shared window helpers.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_timing_pkg;

  localparam int POS_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam logic SYNC_POL_DEF = 1'b0;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  function automatic int axis_total(input int vis, input int front, input int sync,
                                    input int back);
    return vis + front + sync + back;
  endfunction

  // Half-open window test: lo <= p < hi.
  function automatic logic in_window(input logic [POS_W-1:0] p, input int lo, input int hi);
    return (int'(p) >= lo) && (int'(p) < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_axis_counter                                                     |
// | One raster axis: wrapping position counter with look-ahead flags.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL_DEF,
  parameter int VISIBLE    = H_VISIBLE_DEF,
  parameter int SYNC_START = H_SYNC_START_DEF,
  parameter int SYNC_END   = H_SYNC_END_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [POS_W-1:0] pos,
  output logic             wrap,
  output logic             next_visible,
  output logic             next_sync
);

  localparam logic [POS_W-1:0] c_last = POS_W'(TOTAL - 1);

  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;

  // Flags are derived from pos_d so the top can register them in step with pos_q.
  always_comb begin
    wrap = inc && (pos_q == c_last);
    if (wrap) begin
      pos_d = '0;
    end else if (inc) begin
      pos_d = pos_q + POS_W'(1);
    end else begin
      pos_d = pos_q;
    end
    next_visible = in_window(pos_d, 0, VISIBLE);
    next_sync    = in_window(pos_d, SYNC_START, SYNC_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_gen                                                       |
// | Raster timing generator: coordinates, syncs, blanking and strobes.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = H_VISIBLE_DEF,
  parameter int   H_FRONT   = H_FRONT_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BACK    = H_BACK_DEF,
  parameter int   V_VISIBLE = V_VISIBLE_DEF,
  parameter int   V_FRONT   = V_FRONT_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BACK    = V_BACK_DEF,
  parameter logic SYNC_POL  = SYNC_POL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  output logic [POS_W-1:0] hpos,
  output logic [POS_W-1:0] vpos,
  output logic             hsync,
  output logic             vsync,
  output logic             display_on,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int c_h_total      = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int c_v_total      = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int c_h_sync_start = H_VISIBLE + H_FRONT;
  localparam int c_h_sync_end   = c_h_sync_start + H_SYNC;
  localparam int c_v_sync_start = V_VISIBLE + V_FRONT;
  localparam int c_v_sync_end   = c_v_sync_start + V_SYNC;

  // Flag values describing position (0,0), loaded on reset.
  localparam logic c_rst_display =
      in_window('0, 0, H_VISIBLE) && in_window('0, 0, V_VISIBLE);
  localparam logic c_rst_hsync =
      in_window('0, c_h_sync_start, c_h_sync_end) ? SYNC_POL : ~SYNC_POL;
  localparam logic c_rst_vsync =
      in_window('0, c_v_sync_start, c_v_sync_end) ? SYNC_POL : ~SYNC_POL;

  logic w_h_wrap;
  logic w_h_next_vis;
  logic w_h_next_sync;
  logic w_v_wrap;
  logic w_v_next_vis;
  logic w_v_next_sync;

  vga_axis_counter #(
    .TOTAL      (c_h_total),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (c_h_sync_start),
    .SYNC_END   (c_h_sync_end)
  ) u_h_axis (
    .clk          (clk),
    .reset        (reset),
    .inc          (ena),
    .pos          (hpos),
    .wrap         (w_h_wrap),
    .next_visible (w_h_next_vis),
    .next_sync    (w_h_next_sync)
  );

  vga_axis_counter #(
    .TOTAL      (c_v_total),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (c_v_sync_start),
    .SYNC_END   (c_v_sync_end)
  ) u_v_axis (
    .clk          (clk),
    .reset        (reset),
    .inc          (w_h_wrap),
    .pos          (vpos),
    .wrap         (w_v_wrap),
    .next_visible (w_v_next_vis),
    .next_sync    (w_v_next_sync)
  );

  logic       display_q, display_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // The vertical wrap only fires when the horizontal one does, so it marks the frame edge.
  always_comb begin
    display_d     = display_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    frame_cnt_d   = frame_cnt_q;
    if (ena) begin
      display_d     = w_h_next_vis && w_v_next_vis;
      hsync_d       = w_h_next_sync ? SYNC_POL : ~SYNC_POL;
      vsync_d       = w_v_next_sync ? SYNC_POL : ~SYNC_POL;
      line_start_d  = w_h_wrap;
      frame_start_d = w_v_wrap;
      frame_cnt_d   = frame_cnt_q + {7'd0, w_v_wrap};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      display_q     <= c_rst_display;
      hsync_q       <= c_rst_hsync;
      vsync_q       <= c_rst_vsync;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
      frame_cnt_q   <= 8'd0;
    end else begin
      display_q     <= display_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign display_on  = display_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire
